// File: rtl/exp_golomb_reader.sv
// rtl/exp_golomb_reader.sv - Exp-Golomb / fixed-length syntax element reader driving the bitstream buffer pointer
module exp_golomb_reader (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req,
    input  logic [1:0]  mode,
    input  logic [4:0]  flc_len,
    input  logic        te_max_one,
    input  logic        BitStream_buffer_valid_n,
    input  logic [15:0] BitStream_buffer_output,
    output logic [6:0]  pc,
    output logic        busy,
    output logic        done,
    output logic [15:0] value,
    output logic        err
);

    localparam logic [1:0] MODE_FLC = 2'b00;
    localparam logic [1:0] MODE_SE  = 2'b10;
    localparam logic [1:0] MODE_TE  = 2'b11;

    typedef enum logic [1:0] {IDLE, SAMPLE1, WAIT, SAMPLE2} stateType;

    stateType    state;
    logic [1:0]  modeReg;
    logic [4:0]  lenReg;      // 1..16, zero length already folded to 1
    logic        teOneReg;
    logic [3:0]  lzReg;       // prefix length carried from SAMPLE1 into SAMPLE2, 1..15

    logic [4:0]  leadZeros;
    logic [15:0] flcVal;
    logic [15:0] infoBits;
    logic [16:0] codeNum;

    // Maps the code number to the element value; only se needs the signed zig-zag mapping
    function automatic logic [15:0] mapElement(input logic [1:0] m, input logic [16:0] k);
        logic [16:0] s;
        s = k;
        if (m == MODE_SE) begin
            if (k[0])
                s = (k + 17'd1) >> 1;
            else
                s = 17'd0 - (k >> 1);
        end
        return s[15:0];
    endfunction

    // Window decode: prefix zero count, FLC field, and info field / code number for the suffix window
    always_comb begin
        leadZeros = 5'd16;
        for (int i = 0; i < 16; i++) begin
            if (BitStream_buffer_output[i])
                leadZeros = 5'(15 - i);
        end
        flcVal   = BitStream_buffer_output >> (5'd16 - lenReg);
        infoBits = BitStream_buffer_output >> (5'd16 - {1'b0, lzReg});
        codeNum  = ((17'd1 << lzReg) - 17'd1) + {1'b0, infoBits};
    end

    // Request FSM; pc, value, done, err and busy are all registered here
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            pc       <= 7'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            value    <= 16'd0;
            modeReg  <= MODE_FLC;
            lenReg   <= 5'd1;
            teOneReg <= 1'b0;
            lzReg    <= 4'd0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    // busy is still high during the done cycle, so a req there is ignored
                    if (busy) begin
                        busy <= 1'b0;
                    end else if (req) begin
                        modeReg  <= mode;
                        lenReg   <= (flc_len == 5'd0) ? 5'd1 : flc_len;
                        teOneReg <= te_max_one;
                        busy     <= 1'b1;
                        state    <= SAMPLE1;
                    end
                end
                SAMPLE1: begin
                    if (!BitStream_buffer_valid_n) begin
                        if (modeReg == MODE_FLC) begin
                            value <= flcVal;
                            pc    <= pc + 7'(lenReg);
                            done  <= 1'b1;
                            state <= IDLE;
                        end else if (modeReg == MODE_TE && teOneReg) begin
                            value <= {15'd0, ~BitStream_buffer_output[15]};
                            pc    <= pc + 7'd1;
                            done  <= 1'b1;
                            state <= IDLE;
                        end else if (leadZeros == 5'd16) begin
                            value <= 16'd0;
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= IDLE;
                        end else if (leadZeros == 5'd0) begin
                            value <= 16'd0;
                            pc    <= pc + 7'd1;
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            // skip prefix and the terminating 1; suffix arrives after one WAIT cycle
                            lzReg <= leadZeros[3:0];
                            pc    <= pc + 7'(leadZeros) + 7'd1;
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    state <= SAMPLE2;
                end
                SAMPLE2: begin
                    if (!BitStream_buffer_valid_n) begin
                        value <= mapElement(modeReg, codeNum);
                        pc    <= pc + 7'(lzReg);
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/exp_golomb_reader.md
# exp_golomb_reader

Syntax-element reader that sits directly downstream of the bitstream circular buffer. It drives the 7-bit bit pointer `pc` into the buffer and consumes the registered 16-bit window the buffer returns. It decodes one element per request: fixed-length, ue(v), se(v) or te(v). It then advances `pc` by exactly the number of bits consumed, so the slice/macroblock parsers never manipulate the pointer directly.

## Interface
Parameters: none.

Ports:
- `clk` in 1: system clock, all state on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req` in 1: start one element read; sampled only in IDLE.
- `mode` in 2: 00 FLC, 01 ue, 10 se, 11 te; latched on accept.
- `flc_len` in 5: FLC length 1..16; latched on accept; 0 treated as 1.
- `te_max_one` in 1: te range is 1; latched on accept.
- `BitStream_buffer_valid_n` in 1: buffer window not yet valid; active high.
- `BitStream_buffer_output` in 16: window, bit 15 = bit at `pc`; registered one cycle after `pc`.
- `pc` out 7: bit pointer into the 128-bit circular buffer.
- `busy` out 1: request in flight.
- `done` out 1: one-cycle pulse, result valid.
- `value` out 16: result; se is two's complement; held until next `done`.
- `err` out 1: qualifies `done`; no terminating 1 found in prefix window.

## Operation
- States: IDLE, SAMPLE1, WAIT, SAMPLE2.
- IDLE: `req`=1 latches mode/len/te_max_one, sets `busy`, goes to SAMPLE1. `req` while busy is ignored.
- Any SAMPLE state with `valid_n`=1: hold state, no pc change (stall).
- SAMPLE1, FLC: `value` = top `flc_len` bits of window, zero-extended. `pc` += `flc_len`. Set `done`, go to IDLE.
- SAMPLE1, te with `te_max_one`: read 1 bit b. `value` = !b. `pc` += 1. Set `done`.
- SAMPLE1, ue/se/te (otherwise): lz = leading zeros of window, 0..16.
  - lz=16: `err`=1, `done`=1, `value`=0, `pc` unchanged, go to IDLE.
  - lz=0: `pc` += 1; k=0; finish.
  - Else: `pc` += lz+1; go to WAIT.
- WAIT: exactly one cycle, so the buffer registers the window for the new `pc`. Then SAMPLE2.
- SAMPLE2: info = top lz bits. k = (1<<lz) − 1 + info; max 65534. `pc` += lz. Finish.
- Finish: ue/te `value` = k. se `value` = (k+1)>>1 if k odd, else −(k>>1); 17-bit internal, truncated to 16.
- `pc` arithmetic is modulo 128; wrap past 127 is normal. Window wrap is the buffer's concern.
- Reset (async, any state): state IDLE, `pc`=0, `busy`=0, `done`=0, `err`=0, `value`=0. An in-flight request is discarded.

## Timing
- `req` accepted in cycle t.
- FLC, 1-bit te, lz=0 ue: `done` at t+2, with `pc` updated on the same edge.
- ue with lz≥1: `done` at t+4. Extra stall cycles add 1:1.
- `busy` is high t+1 through the `done` cycle; low the cycle after.
- Back-to-back: a `req` in the cycle after `done` is accepted. SAMPLE1 then falls ≥1 cycle after the `pc` update, so the window is fresh with no extra gap.
- `done` and `err` are registered, single-cycle. `value` changes only with `done`.

## Test plan
- FLC: pc=0, window 0xA5F0, flc_len=8 -> `done` at t+2, `value`=0x00A5, pc=8.
- ue: pc=0, bits 00101…
  - SAMPLE1: lz=2, pc→3. SAMPLE2 reads info=01, pc→5.
  - `done` at t+4, `value`=4.
  - Same bits with se -> `value`=0xFFFE (−2).
- ue long code: 15 zeros then 1, then 15 ones across two windows -> `value`=65534, pc advances 31 modulo 128.
- Wrap: pc=120, FLC len 16 -> pc=8. Next ue lz=0 -> `value`=0, pc=9.
- Stall/error:
  - `valid_n`=1 for 3 cycles in SAMPLE1 -> `done` at t+5, pc frozen meanwhile.
  - All-zero window -> `err`=1 with `done`, pc unchanged.
  - `reset_n` low in WAIT -> all outputs 0 immediately.
- te: `te_max_one`=1, bit 0 -> `value`=1, pc+1. `te_max_one`=0 -> identical to ue.
